// File: rtl/otter_icache.sv
// Direct-mapped read-only instruction cache with 0-cycle hits and whole-line burst refill.
// Define ICACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module otter_icache #(
    parameter int LINES = 16,
    parameter int WORDS = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_rden,
    input  logic        cpu_flush,
    output logic [31:0] cpu_instr,
    output logic        cpu_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int WB  = $clog2(WORDS);
    localparam int IB  = $clog2(LINES);
    localparam int OFF = WB + 2;
    localparam int TW  = 32 - OFF - IB;

    typedef enum logic [1:0] {
        S_COMPARE = 2'd0,
        S_REFILL  = 2'd1,
        S_UPDATE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_data [LINES][WORDS];
    logic [TW-1:0]    r_tag  [LINES];
    logic [LINES-1:0] r_valid;
    logic             r_discard;
    logic [WB-1:0]    r_cnt;
    logic [31:0]      r_mem_addr;

    logic [WB-1:0]    w_word;
    logic [IB-1:0]    w_idx;
    logic [TW-1:0]    w_tag;
    logic [IB-1:0]    w_fill_idx;
    logic [TW-1:0]    w_fill_tag;
    logic             w_hit;
    logic             w_miss;
    logic             w_beat;
    logic             w_last;
    logic             w_unused;

    assign w_word     = cpu_addr[OFF-1:2];
    assign w_idx      = cpu_addr[OFF+IB-1:OFF];
    assign w_tag      = cpu_addr[31:OFF+IB];
    // The refill always targets the latched line, whatever the PC does meanwhile.
    assign w_fill_idx = r_mem_addr[OFF+IB-1:OFF];
    assign w_fill_tag = r_mem_addr[31:OFF+IB];
    assign w_unused   = ^{cpu_addr[1:0], r_mem_addr[OFF-1:0]};

    assign w_hit  = (r_state == S_COMPARE) && cpu_rden && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_beat = (r_state == S_REFILL) && mem_rvalid;
    assign w_last = w_beat && (r_cnt == WB'(WORDS - 1));

    assign cpu_valid = w_hit;
    assign cpu_instr = r_data[w_idx][w_word];
    assign mem_req   = (r_state == S_REFILL);
    assign mem_addr  = r_mem_addr;

    // Next-state decode and miss detection
    always_comb begin
        w_next = r_state;
        w_miss = 1'b0;
        case (r_state)
            S_COMPARE: begin
                if (cpu_rden && !w_hit) begin
                    w_next = S_REFILL;
                    w_miss = 1'b1;
                end else begin
                    w_next = S_COMPARE;
                end
            end
            S_REFILL: begin
                if (w_last) begin
                    w_next = S_UPDATE;
                end else begin
                    w_next = S_REFILL;
                end
            end
            S_UPDATE: w_next = S_COMPARE;
            default:  w_next = S_COMPARE;
        endcase
    end

    // State, refill address, beat counter, valid bits and discard flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_COMPARE;
            r_valid    <= '0;
            r_discard  <= 1'b0;
            r_cnt      <= '0;
            r_mem_addr <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_mem_addr <= {w_tag, w_idx, {OFF{1'b0}}};
                r_cnt      <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + WB'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            // A flush always wins over validating the line being installed.
            if (cpu_flush) begin
                r_valid <= '0;
            end else if ((r_state == S_UPDATE) && !r_discard) begin
                r_valid[w_fill_idx] <= 1'b1;
            end else begin
                r_valid <= r_valid;
            end
            if (r_state == S_UPDATE) begin
                r_discard <= 1'b0;
            end else if (cpu_flush && (r_state == S_REFILL)) begin
                r_discard <= 1'b1;
            end else begin
                r_discard <= r_discard;
            end
        end
    end

    // Data and tag arrays (not reset)
    always_ff @(posedge CLK) begin
        if (!RESET && w_beat) begin
            r_data[w_fill_idx][r_cnt] <= mem_rdata;
        end
        if (!RESET && (r_state == S_UPDATE)) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Free-running hit/miss statistics, wrapping at 2^32
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_otter_icache.sv
// Self-checking bench for otter_icache: directed scenarios then randomized fetches,
// checked against a line-map reference model of a direct-mapped cache.
module tb_otter_icache;
    logic        CLK;
    logic        RESET;
    logic [31:0] cpu_addr;
    logic        cpu_rden;
    logic        cpu_flush;
    logic [31:0] cpu_instr;
    logic        cpu_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    otter_icache dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .cpu_addr   (cpu_addr),
        .cpu_rden   (cpu_rden),
        .cpu_flush  (cpu_flush),
        .cpu_instr  (cpu_instr),
        .cpu_valid  (cpu_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          total;
    int          bad;
    logic [31:0] salt;
    bit          m_valid [16];
    logic [31:0] m_line  [16];

    // Main memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] memval(input logic [31:0] a);
        return ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch; on a miss, serve the burst with 'gap' idle cycles before each beat,
    // optionally flushing on beat 'flush_beat'.
    task automatic fetch(input logic [31:0] a, input int gap, input int flush_beat);
        logic [31:0] base;
        int          idx;
        bit          hit;
        bit          discard;
        cpu_addr  = a;
        cpu_rden  = 1'b1;
        cpu_flush = 1'b0;
        idx  = int'((a >> 5) & 32'd15);
        hit  = m_valid[idx] && (m_line[idx] == (a >> 5));
        base = a & 32'hFFFF_FFE0;
        @(negedge CLK);
        chk("lookup_valid", {31'd0, cpu_valid}, {31'd0, hit});
        if (hit) begin
            chk("hit_instr", cpu_instr, memval(a));
            chk("hit_no_req", {31'd0, mem_req}, 32'd0);
            tick();
        end else begin
            tick();
            cpu_addr = $urandom;
            @(negedge CLK);
            chk("refill_req", {31'd0, mem_req}, 32'd1);
            chk("refill_addr", mem_addr, base);
            chk("refill_valid", {31'd0, cpu_valid}, 32'd0);
            discard = 1'b0;
            for (int b = 0; b < 8; b++) begin
                for (int g = 0; g < gap; g++) begin
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                    tick();
                end
                mem_rvalid = 1'b1;
                mem_rdata  = memval(base + 32'(4 * b));
                cpu_flush  = (b == flush_beat);
                tick();
                if (b == flush_beat) begin
                    discard = 1'b1;
                    model_flush();
                end
            end
            mem_rvalid = 1'b0;
            cpu_flush  = 1'b0;
            mem_rdata  = $urandom;
            @(negedge CLK);
            chk("update_req_low", {31'd0, mem_req}, 32'd0);
            chk("update_valid", {31'd0, cpu_valid}, 32'd0);
            tick();
            if (!discard) begin
                m_valid[idx] = 1'b1;
                m_line[idx]  = a >> 5;
                cpu_addr     = a;
                @(negedge CLK);
                chk("post_fill_valid", {31'd0, cpu_valid}, 32'd1);
                chk("post_fill_instr", cpu_instr, memval(a));
                tick();
            end
        end
        cpu_rden = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          fb;
        total      = 0;
        bad        = 0;
        salt       = $urandom;
        RESET      = 1'b1;
        cpu_addr   = 32'h0000_0000;
        cpu_rden   = 1'b0;
        cpu_flush  = 1'b0;
        mem_rdata  = 32'h0000_0000;
        mem_rvalid = 1'b0;
        model_flush();
        tick();
        tick();
        RESET = 1'b0;
        @(negedge CLK);
        chk("reset_req", {31'd0, mem_req}, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        chk("reset_valid", {31'd0, cpu_valid}, 32'd0);
        tick();

        // Cold miss, then the rest of the line hits, then the next line misses.
        fetch(32'h0000_0000, 0, -1);
        for (int w = 1; w < 8; w++) fetch(32'(4 * w), 0, -1);
        fetch(32'h0000_0020, 0, -1);

        // Conflict on index 0, then the evicted line misses again.
        fetch(32'h0000_0200, 0, -1);
        fetch(32'h0000_0000, 0, -1);

        // Beats gapped by two idle cycles each.
        fetch(32'h0000_0044, 2, -1);

        // Flush on beat 4: line stays invalid, refetch misses and refills.
        fetch(32'h0000_0400, 0, 4);
        fetch(32'h0000_0400, 1, -1);

        // Flush in the same cycle as a hit: hit still returned, everything invalid after.
        cpu_addr  = 32'h0000_0408;
        cpu_rden  = 1'b1;
        cpu_flush = 1'b1;
        @(negedge CLK);
        chk("flush_hit_valid", {31'd0, cpu_valid}, 32'd1);
        chk("flush_hit_instr", cpu_instr, memval(32'h0000_0408));
        tick();
        cpu_flush = 1'b0;
        cpu_rden  = 1'b0;
        model_flush();

        // No request: no hit, no miss.
        @(negedge CLK);
        chk("idle_valid", {31'd0, cpu_valid}, 32'd0);
        tick();
        @(negedge CLK);
        chk("idle_no_req", {31'd0, mem_req}, 32'd0);
        fetch(32'h0000_0408, 0, -1);

        // Reset at beat 3 abandons the burst and invalidates everything.
        cpu_addr = 32'h0000_0060;
        cpu_rden = 1'b1;
        tick();
        cpu_rden = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memval(32'h0000_0060 + 32'(4 * b));
            tick();
        end
        mem_rvalid = 1'b0;
        RESET      = 1'b1;
        tick();
        RESET = 1'b0;
        model_flush();
        @(negedge CLK);
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        fetch(32'h0000_0408, 0, -1);

        // Randomized fetches over a small address pool to force hits and conflicts.
        for (int n = 0; n < 80; n++) begin
            a  = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | ($urandom_range(0, 7) << 2);
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            fetch(a, int'($urandom_range(0, 2)), fb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
